pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline stage register with a ready/valid handshake on both sides, a two-entry skid buffer, synchronous flush and a saturating stall counter. Generalises the fixed 32-bit PC/instruction stage register used between pipeline stages: any payload width, and back-pressure without a combinational path from downstream ready to upstream ready. It sits between any two pipeline stages (IF/ID, ID/EX, ...) and carries the stage payload, e.g. {pc, inst}.

## Interface
- DATA_W, 64, payload width in bits (≥1)
- RESET_DATA, 0 (DATA_W bits), payload value after reset and after flush (e.g. NOP encoding)
- CNT_W, 16, width of the stall counter (≥1)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept a payload this cycle
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  stage holds a valid payload
- out_ready  input  1  downstream accepts payload this cycle
- out_data  output  DATA_W  payload presented downstream
- flush  input  1  synchronous discard of all held payloads
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main register (drives out_data) and skid register, each with its own valid bit.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- States: EMPTY (main invalid), BUSY (main valid, skid empty), FULL (both valid). Skid is never valid while main is invalid.
- in_ready = (state != FULL); out_valid = (state != EMPTY). Both are decoded from registered state only.
- EMPTY: accept → main<=in_data, BUSY; else stay EMPTY.
- BUSY: accept & drain → main<=in_data, stay BUSY; accept & !drain → skid<=in_data, FULL; !accept & drain → EMPTY; neither → hold.
- FULL: drain → main<=skid, skid invalid, BUSY; else hold. No accept is possible (in_ready=0).
- flush=1 overrides all of the above: next state EMPTY, main and skid data <= RESET_DATA, and in_data is dropped even if accept is true that cycle. The downstream handshake in the flush cycle still counts as a transfer of the current out_data.
- In EMPTY, out_data holds the last drained value; it is not cleared except by reset or flush. Consumers qualify it with out_valid.
- stall_cnt increments by 1 in each cycle with out_valid & !out_ready and holds at all-ones once it saturates. Flush does not clear it; only rst clears it.
- Order is preserved: the payload accepted first is presented first.

## Timing
- Reset (async assert, outputs valid while rst=1): state EMPTY; out_valid=0; in_ready=1; out_data=RESET_DATA; skid data=RESET_DATA; stall_cnt=0.
- Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N (cycle N+1) when the stage is EMPTY, or when BUSY with drain in the same cycle.
- Throughput: 1 payload/cycle with out_ready held high; no bubbles.
- in_ready drops the cycle after a stall first fills the skid. No payload is lost in that cycle because the skid absorbs it.
- Release from FULL: in the first drain cycle in_ready=0; in_ready=1 from the next cycle.
- Reset asserted mid-transfer discards both entries immediately. The first accept after rst deasserts behaves as from EMPTY.
- Flush takes effect at the next edge: out_valid=0 and in_ready=1 in the following cycle.

## Test plan
- Reset: assert rst mid-stream with both entries valid → out_valid=0, in_ready=1, out_data=RESET_DATA, stall_cnt=0 immediately, without a clock edge.
- Streaming: out_ready=1, feed 0x1..0x8 with in_valid=1 on consecutive cycles → out_data 0x1..0x8 on consecutive cycles starting one cycle later, in_ready always 1, stall_cnt=0.
- Back-pressure: feed 0xA, 0xB, 0xC back-to-back with out_ready=0 from the cycle 0xA appears → FULL after 0xB, in_ready=0, 0xC held upstream. Raise out_ready → outputs 0xA, 0xB, 0xC in order, no loss or duplication.
- Flush in FULL with in_valid=1, in_data=0x55 → next cycle out_valid=0, in_ready=1, 0x55 never appears, out_data=RESET_DATA.
- Stall counter: CNT_W=2, hold out_valid=1 with out_ready=0 for 6 cycles → stall_cnt 1,2,3,3,3,3. A flush leaves it at 3; rst clears it to 0.
- Random: random in_valid/out_ready/flush, 10k cycles, checked against a scoreboard queue. Checks: order preserved; accepted payloads are lost only by flush; a payload is never emitted twice.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with ready/valid on both sides.
// A main register drives the downstream payload and a skid register absorbs
// the one extra beat that can arrive while downstream stalls, so in_ready is
// decoded purely from registered state (no ready-to-ready combinational path).
// Also provides synchronous flush and a saturating stall counter.

module pipe_skid_reg #(
  parameter int unsigned              DATA_W     = 64,
  parameter logic [DATA_W-1:0]        RESET_DATA = {DATA_W{1'b0}},
  parameter int unsigned              CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  // EMPTY: main invalid; BUSY: main valid, skid empty; FULL: both valid.
  // Skid is never valid while main is invalid, so three states suffice.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e              state_r;
  logic [DATA_W-1:0]   main_data_r;
  logic [DATA_W-1:0]   skid_data_r;
  logic                out_valid_r;
  logic                in_ready_r;
  logic [CNT_W-1:0]    stall_cnt_r;

  logic                accept_s;
  logic                drain_s;
  logic                stall_s;

  // Handshake qualifiers, built only from registered ready/valid.
  always_comb begin
    accept_s = in_valid & in_ready_r;
    drain_s  = out_valid_r & out_ready;
    stall_s  = out_valid_r & ~out_ready;
  end

  // Stage FSM: state, payload registers and the registered ready/valid flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      main_data_r <= RESET_DATA;
      skid_data_r <= RESET_DATA;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else if (flush) begin
      // Flush wins over any handshake; an incoming beat is dropped.
      state_r     <= ST_EMPTY;
      main_data_r <= RESET_DATA;
      skid_data_r <= RESET_DATA;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            main_data_r <= in_data;
            state_r     <= ST_BUSY;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end else begin
            // Main keeps the last drained value; consumers qualify with valid.
            state_r <= ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (accept_s && drain_s) begin
            main_data_r <= in_data;
            state_r     <= ST_BUSY;
          end else if (accept_s) begin
            // Downstream stalled while a new beat arrived: park it in skid.
            skid_data_r <= in_data;
            state_r     <= ST_FULL;
            in_ready_r  <= 1'b0;
          end else if (drain_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_FULL: begin
          if (drain_s) begin
            // Oldest beat left; promote the skid entry to the main register.
            main_data_r <= skid_data_r;
            state_r     <= ST_BUSY;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= ST_FULL;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles where a valid payload is held back downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_data_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: a table of directed vectors,
// hand-written reset/stall sequences and a scoreboarded random run.

module tb_pipe_skid_reg;

  localparam logic [15:0] RST_D = 16'hDEAD;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        a_in_ready, a_out_valid;
  logic [15:0] a_out_data;
  logic [15:0] a_stall;
  logic        b_in_ready, b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_stall;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_skid_reg #(.DATA_W(16), .RESET_DATA(RST_D), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .flush(flush), .stall_cnt(a_stall)
  );

  pipe_skid_reg #(.DATA_W(16), .RESET_DATA(RST_D), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .flush(flush), .stall_cnt(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] din;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [15:0] e_dout;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [15:0] din, logic ordy, logic fl,
                              logic e_ov, logic e_ir, logic [15:0] e_dout,
                              logic [15:0] e_stall);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_dout = e_dout; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic iv, logic [15:0] d, logic ordy, logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
  endtask

  // one clock edge, then settle to a sampling point away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q[$];
  logic [15:0] held;
  logic [15:0] sa;
  logic [1:0]  sb;
  logic        m_acc, m_drn, m_stl, r_iv, r_or, r_fl;
  logic [15:0] r_d;

  initial begin
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("reset out_valid", {15'd0, a_out_valid}, 16'd0);
    chk("reset in_ready", {15'd0, a_in_ready}, 16'd1);
    chk("reset out_data", a_out_data, RST_D);
    chk("reset stall_cnt", a_stall, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // streaming 1..8, then idle drain
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b1, 16'(i), 1'b1, 1'b0, 1'b1, 1'b1, 16'(i), 16'd0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0008, 16'd0));
    // back-pressure A, B, C
    vecs.push_back(mk(1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000A, 16'd0));
    vecs.push_back(mk(1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 1'b0, 16'h000A, 16'd1));
    vecs.push_back(mk(1'b1, 16'h000C, 1'b0, 1'b0, 1'b1, 1'b0, 16'h000A, 16'd2));
    vecs.push_back(mk(1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000B, 16'd2));
    vecs.push_back(mk(1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000C, 16'd2));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000C, 16'd2));
    // flush while FULL with 0x55 offered
    vecs.push_back(mk(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 16'd2));
    vecs.push_back(mk(1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0011, 16'd3));
    vecs.push_back(mk(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0, 1'b1, RST_D, 16'd4));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, RST_D, 16'd4));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
      tick();
      chk($sformatf("vec%0d out_valid", i), {15'd0, a_out_valid}, {15'd0, vecs[i].e_ov});
      chk($sformatf("vec%0d in_ready", i), {15'd0, a_in_ready}, {15'd0, vecs[i].e_ir});
      chk($sformatf("vec%0d out_data", i), a_out_data, vecs[i].e_dout);
      chk($sformatf("vec%0d stall_cnt", i), a_stall, vecs[i].e_stall);
    end

    // reset mid-stream with both entries valid, checked without a clock edge
    drive(1'b1, 16'h0031, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0032, 1'b0, 1'b0);
    tick();
    chk("prefill in_ready", {15'd0, a_in_ready}, 16'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {15'd0, a_out_valid}, 16'd0);
    chk("async rst in_ready", {15'd0, a_in_ready}, 16'd1);
    chk("async rst out_data", a_out_data, RST_D);
    chk("async rst stall_cnt", a_stall, 16'd0);
    #2 rst = 1'b0;
    drive(1'b1, 16'h0077, 1'b1, 1'b0);
    tick();
    chk("post-rst out_valid", {15'd0, a_out_valid}, 16'd1);
    chk("post-rst out_data", a_out_data, 16'h0077);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    tick();

    // saturating stall counter on the 2-bit instance
    drive(1'b1, 16'h0007, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("sat stall b cyc%0d", i), {14'd0, b_stall}, (i < 3) ? 16'(i) : 16'd3);
      chk($sformatf("sat stall a cyc%0d", i), a_stall, 16'(i));
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    chk("flush keeps stall b", {14'd0, b_stall}, 16'd3);
    chk("flush keeps stall a", a_stall, 16'd7);
    chk("flush out_valid", {15'd0, b_out_valid}, 16'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rst clears stall b", {14'd0, b_stall}, 16'd0);
    #2 rst = 1'b0;
    tick();

    // random traffic against a queue model
    q.delete();
    held = RST_D;
    sa = 16'd0;
    sb = 2'd0;
    for (int c = 0; c < 10000; c++) begin
      r_iv = 1'($urandom_range(0, 1));
      r_or = ($urandom_range(0, 3) != 0);
      r_fl = ($urandom_range(0, 31) == 0);
      r_d  = 16'($urandom);
      drive(r_iv, r_d, r_or, r_fl);
      m_acc = r_iv & (q.size() < 2);
      m_drn = (q.size() > 0) & r_or;
      m_stl = (q.size() > 0) & ~r_or;
      tick();
      if (r_fl) begin
        q.delete();
        held = RST_D;
      end else begin
        if (m_drn) void'(q.pop_front());
        if (m_acc) q.push_back(r_d);
        if (q.size() > 0) held = q[0];
      end
      if (m_stl && (sa != 16'hFFFF)) sa = sa + 16'd1;
      if (m_stl && (sb != 2'd3)) sb = sb + 2'd1;
      chk("rand out_valid", {15'd0, a_out_valid}, {15'd0, (q.size() > 0)});
      chk("rand in_ready", {15'd0, a_in_ready}, {15'd0, (q.size() < 2)});
      chk("rand out_data", a_out_data, held);
      chk("rand stall a", a_stall, sa);
      chk("rand stall b", {14'd0, b_stall}, {14'd0, sb});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
